// File: rtl/cpu_stack_pkg.sv
// Shared encodings for the CALL/RET stack-port initiator: FSM states,
// abort codes and the push/pop strobe polarity.
package cpu_stack_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUSH_LO = 3'd1;
    localparam logic [2:0] S_PUSH_HI = 3'd2;
    localparam logic [2:0] S_POP_HI  = 3'd3;
    localparam logic [2:0] S_POP_LO  = 3'd4;
    localparam logic [2:0] S_CAP_LO  = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVF      = 2'd1;
    localparam logic [1:0] ERR_UNF      = 2'd2;
    localparam logic [1:0] ERR_CONFLICT = 2'd3;

    localparam logic STK_PUSH = 1'b1;
    localparam logic STK_POP  = 1'b0;

endpackage

// File: rtl/call_ret_sequencer.sv
// Turns one CALL/RET request into byte-wide push/pop strobes to the hardware
// stack; CALL pushes low byte first, RET pops high byte first.
module call_ret_sequencer
    import cpu_stack_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NEST_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] call_addr,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [NEST_W-1:0] call_depth,
    output logic              stk_en,
    output logic              stk_push,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    input  logic              stk_empty,
    input  logic              stk_full
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] hi_q;
    logic [1:0]        fin_code;
    logic              fin_ret;

    // Popped bytes arrive one cycle after their strobe is visible, so the
    // high byte lands in CAP_LO and the low byte in FIN. ret_addr is only
    // committed in FIN so an aborted RET leaves the previous PC intact.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            ret_addr   <= '0;
            call_depth <= '0;
            stk_en     <= 1'b0;
            stk_push   <= 1'b0;
            stk_wdata  <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            fin_code   <= ERR_NONE;
            fin_ret    <= 1'b0;
        end else begin
            stk_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            case (state)
                S_IDLE: begin
                    fin_code <= ERR_NONE;
                    fin_ret  <= 1'b0;
                    if (call_req && ret_req) begin
                        fin_code <= ERR_CONFLICT;
                        state    <= S_FIN;
                        ready    <= 1'b0;
                    end else if (call_req) begin
                        addr_q <= call_addr;
                        state  <= S_PUSH_LO;
                        ready  <= 1'b0;
                    end else if (ret_req) begin
                        state <= S_POP_HI;
                        ready <= 1'b0;
                    end
                end
                S_PUSH_LO: begin
                    if (stk_full) begin
                        fin_code <= ERR_OVF;
                        state    <= S_FIN;
                    end else begin
                        stk_en    <= 1'b1;
                        stk_push  <= STK_PUSH;
                        stk_wdata <= addr_q[DATA_W-1:0];
                        state     <= S_PUSH_HI;
                    end
                end
                S_PUSH_HI: begin
                    if (stk_full) begin
                        fin_code <= ERR_OVF;
                        state    <= S_FIN;
                    end else begin
                        stk_en    <= 1'b1;
                        stk_push  <= STK_PUSH;
                        stk_wdata <= addr_q[ADDR_W-1:DATA_W];
                        state     <= S_FIN;
                        if (call_depth != '1)
                            call_depth <= call_depth + NEST_W'(1);
                    end
                end
                S_POP_HI: begin
                    if (stk_empty) begin
                        fin_code <= ERR_UNF;
                        state    <= S_FIN;
                    end else begin
                        stk_en   <= 1'b1;
                        stk_push <= STK_POP;
                        state    <= S_POP_LO;
                    end
                end
                S_POP_LO: begin
                    if (stk_empty) begin
                        fin_code <= ERR_UNF;
                        state    <= S_FIN;
                    end else begin
                        stk_en   <= 1'b1;
                        stk_push <= STK_POP;
                        state    <= S_CAP_LO;
                    end
                end
                S_CAP_LO: begin
                    hi_q    <= stk_rdata;
                    fin_ret <= 1'b1;
                    state   <= S_FIN;
                    if (call_depth != '0)
                        call_depth <= call_depth - NEST_W'(1);
                end
                S_FIN: begin
                    done     <= 1'b1;
                    err      <= (fin_code != ERR_NONE);
                    err_code <= fin_code;
                    if (fin_ret)
                        ret_addr <= {hi_q, stk_rdata};
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Random CALL/RET traffic against a 16-byte stack responder; a byte-queue
// reference model predicts each done pulse and every strobe.
module tb_call_ret_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [15:0] call_addr = '0;
    logic        ready, done, err;
    logic [1:0]  err_code;
    logic [15:0] ret_addr;
    logic [3:0]  call_depth;
    logic        stk_en, stk_push;
    logic [7:0]  stk_wdata, stk_rdata;
    logic        stk_empty, stk_full;

    call_ret_sequencer #(.ADDR_W(16), .DATA_W(8), .NEST_W(4)) dut (
        .clock(clock), .reset(reset), .call_req(call_req), .ret_req(ret_req),
        .call_addr(call_addr), .ready(ready), .done(done), .err(err),
        .err_code(err_code), .ret_addr(ret_addr), .call_depth(call_depth),
        .stk_en(stk_en), .stk_push(stk_push), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stack responder: flags account for a strobe already on the wire, pop
    // data is registered so it appears the cycle after the strobe.
    logic [7:0] smem [16];
    int         scnt = 0;
    logic [7:0] srd = '0;
    logic       side_push = 1'b0, side_clr = 1'b0;
    logic [7:0] side_data = '0;

    assign stk_rdata = srd;
    assign stk_full  = (scnt + ((stk_en && stk_push) ? 1 : 0)) >= 16;
    assign stk_empty = (scnt - ((stk_en && !stk_push) ? 1 : 0)) <= 0;

    always @(posedge clock) begin
        if (stk_en && stk_push) begin
            if (scnt < 16) begin
                smem[scnt[3:0]] <= stk_wdata;
                scnt <= scnt + 1;
            end
        end else if (stk_en) begin
            if (scnt > 0) begin
                srd  <= smem[4'(scnt - 1)];
                scnt <= scnt - 1;
            end
        end else if (side_clr) begin
            scnt <= 0;
        end else if (side_push && scnt < 16) begin
            smem[scnt[3:0]] <= side_data;
            scnt <= scnt + 1;
        end
    end

    // Reference model
    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [15:0] ra;
        logic [3:0]  dep;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        expq[$];
    logic [8:0]  stbq[$];
    logic [7:0]  mq[$];
    int          mdep = 0;
    logic [15:0] mra = '0;

    // kind: 0=CALL, 1=RET, 2=both requests
    task automatic model_op(input int kind, input logic [15:0] a, input int acc);
        exp_t e;
        logic [7:0] hi, lo;
        e.err = 1'b0; e.code = 2'd0; e.acc = acc; e.lat = 0;
        if (kind == 2) begin
            e.err = 1'b1; e.code = 2'd3; e.lat = 1;
        end else if (kind == 0) begin
            if (mq.size() >= 16) begin
                e.err = 1'b1; e.code = 2'd1; e.lat = 2;
            end else begin
                mq.push_back(a[7:0]);
                stbq.push_back({1'b1, a[7:0]});
                if (mq.size() >= 16) begin
                    e.err = 1'b1; e.code = 2'd1; e.lat = 3;
                end else begin
                    mq.push_back(a[15:8]);
                    stbq.push_back({1'b1, a[15:8]});
                    if (mdep < 15) mdep++;
                    e.lat = 3;
                end
            end
        end else begin
            if (mq.size() == 0) begin
                e.err = 1'b1; e.code = 2'd2; e.lat = 2;
            end else begin
                hi = mq.pop_back();
                stbq.push_back(9'h000);
                if (mq.size() == 0) begin
                    e.err = 1'b1; e.code = 2'd2; e.lat = 3;
                end else begin
                    lo = mq.pop_back();
                    stbq.push_back(9'h000);
                    mra = {hi, lo};
                    if (mdep > 0) mdep--;
                    e.lat = 4;
                end
            end
        end
        e.ra  = mra;
        e.dep = 4'(mdep);
        expq.push_back(e);
    endtask

    // Monitor: compares every done pulse and every strobe against the queues
    exp_t       me;
    logic [8:0] ms;
    always @(negedge clock) begin
        if (!reset && done) begin
            if (expq.size() == 0) begin
                chk("done_without_request", 32'(done), 32'd0);
            end else begin
                me = expq.pop_front();
                chk("err", 32'(err), 32'(me.err));
                chk("err_code", 32'(err_code), 32'(me.code));
                chk("ret_addr", 32'(ret_addr), 32'(me.ra));
                chk("call_depth", 32'(call_depth), 32'(me.dep));
                chk("latency", 32'(cyc - me.acc), 32'(me.lat));
                chk("ready_with_done", 32'(ready), 32'd1);
            end
        end
        if (!reset && stk_en) begin
            if (stbq.size() == 0) begin
                chk("unexpected_strobe", 32'(stk_en), 32'd0);
            end else begin
                ms = stbq.pop_front();
                chk("stk_push", 32'(stk_push), 32'(ms[8]));
                if (ms[8]) chk("stk_wdata", 32'(stk_wdata), 32'(ms[7:0]));
            end
        end
    end

    task automatic issue(input int kind, input logic [15:0] a);
        int n;
        n = 0;
        @(negedge clock);
        while (!ready && n < 50) begin
            // requests while busy must be dropped
            call_req  = ($urandom_range(0, 3) == 0);
            ret_req   = ($urandom_range(0, 3) == 0);
            call_addr = 16'($urandom);
            @(negedge clock);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            call_req = 1'b0; ret_req = 1'b0;
            return;
        end
        model_op(kind, a, cyc + 1);
        call_req  = (kind != 1);
        ret_req   = (kind != 0);
        call_addr = a;
        @(negedge clock);
        call_req = 1'b0;
        ret_req  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (expq.size() != 0) chk("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    task automatic side_fill(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            side_push = 1'b1;
            side_data = 8'($urandom);
            mq.push_back(side_data);
        end
        @(negedge clock);
        side_push = 1'b0;
    endtask

    task automatic side_clear();
        @(negedge clock);
        side_clr = 1'b1;
        @(negedge clock);
        side_clr = 1'b0;
        mq.delete();
    endtask

    initial begin
        int r, room;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_ret_addr", 32'(ret_addr), 32'd0);
        chk("rst_call_depth", 32'(call_depth), 32'd0);
        chk("rst_stk_en", 32'(stk_en), 32'd0);
        chk("rst_stk_push", 32'(stk_push), 32'd0);
        chk("rst_stk_wdata", 32'(stk_wdata), 32'd0);
        reset = 1'b0;

        issue(0, 16'h1234);
        drain();
        issue(1, 16'h0000);
        drain();
        chk("empty_after_ret", 32'(stk_empty), 32'd1);

        issue(0, 16'hA001);
        issue(0, 16'hB002);
        issue(1, 16'h0000);
        issue(1, 16'h0000);
        drain();

        issue(1, 16'h0000);
        drain();
        issue(2, 16'h7777);
        drain();

        side_fill(15);
        issue(0, 16'hFFEE);
        drain();
        chk("stack_full_count", 32'(scnt), 32'd16);
        side_clear();

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 45) issue(0, 16'($urandom));
            else if (r < 85) issue(1, 16'h0000);
            else if (r < 90) issue(2, 16'($urandom));
            else if (r < 95) begin
                drain();
                room = 16 - mq.size();
                if (room > 0) side_fill($urandom_range(1, room));
            end else begin
                drain();
                side_clear();
            end
        end
        drain();
        chk("model_vs_stack_bytes", 32'(scnt), 32'(mq.size()));

        // Reset while the high byte is about to go out
        issue(0, 16'h5566);
        if (mq.size() == 0) side_fill(0);
        @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("midrst_stk_en", 32'(stk_en), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_call_depth", 32'(call_depth), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        expq.delete();
        stbq.delete();
        // the high byte never made it; the low byte stays on the stack
        if (mq.size() >= 2 && mq[mq.size()-1] == 8'h55) void'(mq.pop_back());
        mdep = 0;
        mra = '0;
        chk("midrst_stack_bytes", 32'(scnt), 32'(mq.size()));
        reset = 1'b0;
        side_clear();
        issue(0, 16'hC0DE);
        issue(1, 16'h0000);
        drain();

        chk("leftover_expect", 32'(expq.size()), 32'd0);
        chk("leftover_strobes", 32'(stbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
